n2_tlb_acc_seq: RTL and testbench
=================================

Name: n2_tlb_acc_seq

Overview:
- TLB access sequencer; initiator side of the 128-entry TLB array write/read/demap/CAM interface.
- Accepts one MMU maintenance request at a time (write, read, demap) and arbitrates it against CAM lookups, which have priority.
- Drives the array control strobes with fixed timing and captures read-back TTE tag/data with a parity check.
- Owns the round-robin replacement pointer used for un-indexed writes.

Parameters:
- RD_LAT, 1, cycles from tlb_rd_vld to valid tlb_tte_* read data; legal values 1..3.
- DMAP_GAP, 1, idle cycles forced after a demap strobe before the next maintenance op; legal values 0..3.

Ports:
- l2clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cam_req  in  1  lookup request from the pipe; highest priority
- req_vld  in  1  maintenance request valid
- req_rdy  out  1  request accepted when req_vld and req_rdy are both high
- req_op  in  2  00 write, 01 read, 10 demap, 11 reserved (accepted, no array op, rsp_err=1)
- req_index  in  7  entry index
- req_index_vld  in  1  index is explicit; 0 on a write means use the replacement pointer
- req_dmap_ctx  in  1  demap qualifier: context
- req_dmap_all  in  1  demap qualifier: all
- req_dmap_real  in  1  demap qualifier: real
- req_tag  in  66  TTE tag for writes and demaps
- req_ubit  in  1  TTE used bit
- req_psz  in  3  page-size mask
- req_data  in  38  TTE data
- tlb_cam_vld, tlb_wr_vld, tlb_rd_vld, tlb_demap  out  1 each  array strobes
- tlb_demap_context, tlb_demap_all, tlb_demap_real  out  1 each  demap qualifiers
- tlb_rw_index  out  7  array index
- tlb_rw_index_vld  out  1  index valid
- tte_tag  out  66  to the array
- tte_ubit  out  1  to the array
- tte_page_size_mask  out  3  to the array
- tte_data  out  38  to the array
- tlb_tte_tag  in  66  array read data
- tlb_tte_data  in  38  array read data
- tlb_tte_u_bit  in  1  array read data
- tlb_tte_data_parity  in  1  array read data parity
- rsp_vld  out  1  one-cycle completion pulse
- rsp_tag  out  66  read-back tag
- rsp_data  out  38  read-back data
- rsp_ubit  out  1  read-back used bit
- rsp_err  out  1  parity error or reserved op
- repl_ptr  out  7  current replacement pointer

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; repl_ptr=0; captured request cleared. Reset mid-operation abandons the op with no rsp_vld.
- tlb_cam_vld equals cam_req, combinational, in every state. No maintenance strobe is asserted in a cycle where cam_req=1.
- FSM states: IDLE, PEND, RDW, GAP, RSP.
  - IDLE: req_rdy=1. On handshake, capture all req_* fields; go to PEND.
  - PEND: req_rdy=0. If cam_req=1, stay in PEND.
  - PEND with cam_req=0, write: assert tlb_wr_vld for exactly 1 cycle; go to RSP.
  - PEND with cam_req=0, read: assert tlb_rd_vld for exactly 1 cycle; go to RDW.
  - PEND with cam_req=0, demap: assert tlb_demap with its qualifiers for exactly 1 cycle; go to GAP when DMAP_GAP>0, otherwise RSP.
  - PEND with cam_req=0, reserved op: go directly to RSP.
  - RDW: count RD_LAT cycles. Sample tlb_tte_* in the cycle the count reaches RD_LAT. rsp_err = (^tlb_tte_data) != tlb_tte_data_parity (even parity). Go to RSP.
  - GAP: count DMAP_GAP idle cycles; go to RSP.
  - RSP: rsp_vld=1 for 1 cycle; go to IDLE. rsp_tag, rsp_data, rsp_ubit and rsp_err hold until the next rsp_vld. Writes and demaps return rsp_err=0, except reserved op returns rsp_err=1.
- Throughput: minimum handshake-to-handshake spacing is 3 cycles for a write; a new req_vld is accepted the cycle after RSP.
- Array drive timing:
  - tlb_rw_index, tlb_rw_index_vld, tte_* and the demap qualifiers are driven from the captured request only in a strobe cycle; 0 otherwise.
  - tlb_rw_index_vld is 1 for reads and writes.
- Replacement:
  - A write with req_index_vld=0 uses tlb_rw_index=repl_ptr.
  - repl_ptr increments modulo 128 in the strobe cycle (127 -> 0).
  - Explicit-index writes leave repl_ptr unchanged.
  - A demap with req_dmap_all=1 resets repl_ptr to 0 in the strobe cycle.

Test Plan:
- Write, index_vld=0, repl_ptr=127, cam_req=0 -> tlb_wr_vld for 1 cycle with tlb_rw_index=127; repl_ptr becomes 0; rsp_vld 1 cycle later with rsp_err=0.
- Read idx=5, RD_LAT=2, array returns tlb_tte_data=38'h1 with tlb_tte_data_parity=1 -> tlb_rd_vld 1 cycle; rsp_data=38'h1, rsp_err=0. Repeat with parity=0 -> rsp_err=1.
- cam_req held high 4 cycles while a write is pending -> tlb_wr_vld never overlaps tlb_cam_vld; the write strobes in the first cycle cam_req=0.
- Demap with all=1, DMAP_GAP=2 -> tlb_demap and tlb_demap_all 1 cycle; 2 gap cycles; rsp_vld; repl_ptr=0; req_rdy low throughout.
- Reserved op 11 -> no array strobe; rsp_vld with rsp_err=1.
- reset asserted in RDW -> all outputs 0 immediately; no rsp_vld; req_rdy=1 after deassertion.

Source files
------------

// File: rtl/n2_tlb_acc_seq.sv
// rtl/n2_tlb_acc_seq.sv - TLB access sequencer: arbitrates maintenance ops against CAM lookups
// and drives the 128-entry TLB array strobes, read-back capture and replacement pointer.
module n2_tlb_acc_seq #(
  parameter int RD_LAT   = 1,
  parameter int DMAP_GAP = 1
) (
  input  logic        l2clk,
  input  logic        reset,
  input  logic        cam_req,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_index,
  input  logic        req_index_vld,
  input  logic        req_dmap_ctx,
  input  logic        req_dmap_all,
  input  logic        req_dmap_real,
  input  logic [65:0] req_tag,
  input  logic        req_ubit,
  input  logic [2:0]  req_psz,
  input  logic [37:0] req_data,
  output logic        tlb_cam_vld,
  output logic        tlb_wr_vld,
  output logic        tlb_rd_vld,
  output logic        tlb_demap,
  output logic        tlb_demap_context,
  output logic        tlb_demap_all,
  output logic        tlb_demap_real,
  output logic [6:0]  tlb_rw_index,
  output logic        tlb_rw_index_vld,
  output logic [65:0] tte_tag,
  output logic        tte_ubit,
  output logic [2:0]  tte_page_size_mask,
  output logic [37:0] tte_data,
  input  logic [65:0] tlb_tte_tag,
  input  logic [37:0] tlb_tte_data,
  input  logic        tlb_tte_u_bit,
  input  logic        tlb_tte_data_parity,
  output logic        rsp_vld,
  output logic [65:0] rsp_tag,
  output logic [37:0] rsp_data,
  output logic        rsp_ubit,
  output logic        rsp_err,
  output logic [6:0]  repl_ptr
);

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_DM = 2'b10;
  localparam logic [1:0] RD_LAT_C   = 2'(RD_LAT);
  localparam logic [1:0] DMAP_GAP_C = 2'(DMAP_GAP);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    RDW  = 3'd2,
    GAP  = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  cnt;

  logic [1:0]  c_op;
  logic [6:0]  c_index;
  logic        c_index_vld;
  logic        c_dmap_ctx;
  logic        c_dmap_all;
  logic        c_dmap_real;
  logic [65:0] c_tag;
  logic        c_ubit;
  logic [2:0]  c_psz;
  logic [37:0] c_data;

  logic fire;
  logic wr_stb;
  logic rd_stb;
  logic dm_stb;
  logic any_stb;

  // Strobes are decided in the same cycle as cam_req so a lookup can never overlap them.
  assign fire    = (state == PEND) && !cam_req;
  assign wr_stb  = fire && (c_op == OP_WR);
  assign rd_stb  = fire && (c_op == OP_RD);
  assign dm_stb  = fire && (c_op == OP_DM);
  assign any_stb = wr_stb || rd_stb || dm_stb;

  assign tlb_cam_vld        = cam_req;
  assign tlb_wr_vld         = wr_stb;
  assign tlb_rd_vld         = rd_stb;
  assign tlb_demap          = dm_stb;
  assign tlb_demap_context  = dm_stb && c_dmap_ctx;
  assign tlb_demap_all      = dm_stb && c_dmap_all;
  assign tlb_demap_real     = dm_stb && c_dmap_real;
  assign tlb_rw_index_vld   = wr_stb || rd_stb;
  assign tlb_rw_index       = !any_stb ? 7'd0 : ((wr_stb && !c_index_vld) ? repl_ptr : c_index);
  assign tte_tag            = any_stb ? c_tag  : 66'd0;
  assign tte_ubit           = any_stb && c_ubit;
  assign tte_page_size_mask = any_stb ? c_psz  : 3'd0;
  assign tte_data           = any_stb ? c_data : 38'd0;

  always_ff @(posedge l2clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      req_rdy     <= 1'b0;
      rsp_vld     <= 1'b0;
      rsp_tag     <= 66'd0;
      rsp_data    <= 38'd0;
      rsp_ubit    <= 1'b0;
      rsp_err     <= 1'b0;
      repl_ptr    <= 7'd0;
      c_op        <= 2'd0;
      c_index     <= 7'd0;
      c_index_vld <= 1'b0;
      c_dmap_ctx  <= 1'b0;
      c_dmap_all  <= 1'b0;
      c_dmap_real <= 1'b0;
      c_tag       <= 66'd0;
      c_ubit      <= 1'b0;
      c_psz       <= 3'd0;
      c_data      <= 38'd0;
    end else begin
      rsp_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld && req_rdy) begin
            c_op        <= req_op;
            c_index     <= req_index;
            c_index_vld <= req_index_vld;
            c_dmap_ctx  <= req_dmap_ctx;
            c_dmap_all  <= req_dmap_all;
            c_dmap_real <= req_dmap_real;
            c_tag       <= req_tag;
            c_ubit      <= req_ubit;
            c_psz       <= req_psz;
            c_data      <= req_data;
            req_rdy     <= 1'b0;
            state       <= PEND;
          end else begin
            req_rdy <= 1'b1;
          end
        end
        PEND: begin
          if (!cam_req) begin
            case (c_op)
              OP_WR: begin
                if (!c_index_vld) begin
                  repl_ptr <= repl_ptr + 7'd1;
                end
                rsp_err <= 1'b0;
                rsp_vld <= 1'b1;
                state   <= RSP;
              end
              OP_RD: begin
                cnt   <= 2'd1;
                state <= RDW;
              end
              OP_DM: begin
                if (c_dmap_all) begin
                  repl_ptr <= 7'd0;
                end
                if (DMAP_GAP_C != 2'd0) begin
                  cnt   <= 2'd1;
                  state <= GAP;
                end else begin
                  rsp_err <= 1'b0;
                  rsp_vld <= 1'b1;
                  state   <= RSP;
                end
              end
              default: begin
                rsp_err <= 1'b1;
                rsp_vld <= 1'b1;
                state   <= RSP;
              end
            endcase
          end
        end
        RDW: begin
          // Array data is valid exactly RD_LAT cycles after the read strobe.
          if (cnt == RD_LAT_C) begin
            rsp_tag  <= tlb_tte_tag;
            rsp_data <= tlb_tte_data;
            rsp_ubit <= tlb_tte_u_bit;
            rsp_err  <= (^tlb_tte_data) != tlb_tte_data_parity;
            rsp_vld  <= 1'b1;
            state    <= RSP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        GAP: begin
          if (cnt == DMAP_GAP_C) begin
            rsp_err <= 1'b0;
            rsp_vld <= 1'b1;
            state   <= RSP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RSP: begin
          req_rdy <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n2_tlb_acc_seq.sv
// tb/tb_n2_tlb_acc_seq.sv - directed bench for n2_tlb_acc_seq with a per-cycle schedule model
// built from the access rules, compared against the DUT every cycle.
module tb_n2_tlb_acc_seq;

  localparam int RD_LAT   = 2;
  localparam int DMAP_GAP = 2;
  localparam int NCYC     = 600;

  logic        l2clk;
  logic        reset;
  logic        cam_req;
  logic        req_vld;
  logic        req_rdy;
  logic [1:0]  req_op;
  logic [6:0]  req_index;
  logic        req_index_vld;
  logic        req_dmap_ctx;
  logic        req_dmap_all;
  logic        req_dmap_real;
  logic [65:0] req_tag;
  logic        req_ubit;
  logic [2:0]  req_psz;
  logic [37:0] req_data;
  logic        tlb_cam_vld;
  logic        tlb_wr_vld;
  logic        tlb_rd_vld;
  logic        tlb_demap;
  logic        tlb_demap_context;
  logic        tlb_demap_all;
  logic        tlb_demap_real;
  logic [6:0]  tlb_rw_index;
  logic        tlb_rw_index_vld;
  logic [65:0] tte_tag;
  logic        tte_ubit;
  logic [2:0]  tte_page_size_mask;
  logic [37:0] tte_data;
  logic [65:0] tlb_tte_tag;
  logic [37:0] tlb_tte_data;
  logic        tlb_tte_u_bit;
  logic        tlb_tte_data_parity;
  logic        rsp_vld;
  logic [65:0] rsp_tag;
  logic [37:0] rsp_data;
  logic        rsp_ubit;
  logic        rsp_err;
  logic [6:0]  repl_ptr;

  n2_tlb_acc_seq #(.RD_LAT(RD_LAT), .DMAP_GAP(DMAP_GAP)) dut (
    .l2clk(l2clk), .reset(reset), .cam_req(cam_req),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_index(req_index), .req_index_vld(req_index_vld),
    .req_dmap_ctx(req_dmap_ctx), .req_dmap_all(req_dmap_all), .req_dmap_real(req_dmap_real),
    .req_tag(req_tag), .req_ubit(req_ubit), .req_psz(req_psz), .req_data(req_data),
    .tlb_cam_vld(tlb_cam_vld), .tlb_wr_vld(tlb_wr_vld), .tlb_rd_vld(tlb_rd_vld),
    .tlb_demap(tlb_demap), .tlb_demap_context(tlb_demap_context),
    .tlb_demap_all(tlb_demap_all), .tlb_demap_real(tlb_demap_real),
    .tlb_rw_index(tlb_rw_index), .tlb_rw_index_vld(tlb_rw_index_vld),
    .tte_tag(tte_tag), .tte_ubit(tte_ubit), .tte_page_size_mask(tte_page_size_mask),
    .tte_data(tte_data), .tlb_tte_tag(tlb_tte_tag), .tlb_tte_data(tlb_tte_data),
    .tlb_tte_u_bit(tlb_tte_u_bit), .tlb_tte_data_parity(tlb_tte_data_parity),
    .rsp_vld(rsp_vld), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_ubit(rsp_ubit),
    .rsp_err(rsp_err), .repl_ptr(repl_ptr)
  );

  typedef struct packed {
    logic        rst;
    logic        cam;
    logic        vld;
    logic [1:0]  op;
    logic [6:0]  idx;
    logic        ivld;
    logic        ctx;
    logic        all;
    logic        dreal;
    logic [65:0] tag;
    logic        ubit;
    logic [2:0]  psz;
    logic [37:0] data;
    logic [65:0] ttag;
    logic [37:0] tdata;
    logic        tu;
    logic        par;
  } stim_t;

  typedef struct packed {
    logic        rdy;
    logic        wr;
    logic        rd;
    logic        dm;
    logic        dctx;
    logic        dall;
    logic        dreal;
    logic [6:0]  idx;
    logic        idxv;
    logic [65:0] tag;
    logic        ubit;
    logic [2:0]  psz;
    logic [37:0] data;
    logic        rvld;
    logic        rerr;
    logic [65:0] rtag;
    logic [37:0] rdata;
    logic        rubit;
    logic [6:0]  repl;
  } exp_t;

  stim_t in_s [NCYC];
  exp_t  ex   [NCYC];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic built = 1'b0;

  logic [6:0]  m_repl;
  logic [65:0] m_rtag;
  logic [37:0] m_rdata;
  logic        m_rubit;

  int nh, s, r;
  int s1, r1, r2, r3, h4, s5, r5, r6, h7, r7;

  initial begin
    l2clk = 1'b0;
    forever #5 l2clk = ~l2clk;
  end

  always @(posedge l2clk) cyc <= cyc + 1;

  task automatic drive(input int c);
    reset               = in_s[c].rst;
    cam_req             = in_s[c].cam;
    req_vld             = in_s[c].vld;
    req_op              = in_s[c].op;
    req_index           = in_s[c].idx;
    req_index_vld       = in_s[c].ivld;
    req_dmap_ctx        = in_s[c].ctx;
    req_dmap_all        = in_s[c].all;
    req_dmap_real       = in_s[c].dreal;
    req_tag             = in_s[c].tag;
    req_ubit            = in_s[c].ubit;
    req_psz             = in_s[c].psz;
    req_data            = in_s[c].data;
    tlb_tte_tag         = in_s[c].ttag;
    tlb_tte_data        = in_s[c].tdata;
    tlb_tte_u_bit       = in_s[c].tu;
    tlb_tte_data_parity = in_s[c].par;
  endtask

  initial begin
    wait (built);
    forever begin
      drive((cyc < NCYC) ? cyc : NCYC - 1);
      @(posedge l2clk);
      #1;
    end
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic fill_repl(input int from, input logic [6:0] v);
    for (int c = from; c < NCYC; c++) ex[c].repl = v;
  endtask

  // Reset held for cycles [a, b-1], released one tick into cycle b; ready returns in b+1.
  task automatic apply_reset(input int a, input int b);
    for (int c = a; c < b; c++) begin
      in_s[c].rst = 1'b1;
      in_s[c].cam = 1'b0;
    end
    for (int c = a; c < NCYC; c++) begin
      ex[c] = '0;
      ex[c].rdy = (c > b);
    end
    m_repl  = 7'd0;
    m_rtag  = 66'd0;
    m_rdata = 38'd0;
    m_rubit = 1'b0;
  endtask

  // Handshake in cycle h; strobe in the first later cycle without a lookup; the response
  // follows 1 cycle later for writes/reserved, RD_LAT+1 for reads, DMAP_GAP+1 for demaps.
  task automatic issue(input int h, input logic [1:0] op, input logic [6:0] idx,
                       input logic ivld, input logic [2:0] dq, input logic [65:0] tag,
                       input logic [37:0] data, input logic [37:0] rdd, input logic par,
                       output int so, output int ro);
    int st;
    int rc;
    logic err;
    in_s[h].vld   = 1'b1;
    in_s[h].op    = op;
    in_s[h].idx   = idx;
    in_s[h].ivld  = ivld;
    in_s[h].ctx   = dq[2];
    in_s[h].all   = dq[1];
    in_s[h].dreal = dq[0];
    in_s[h].tag   = tag;
    in_s[h].ubit  = tag[0];
    in_s[h].psz   = tag[3:1];
    in_s[h].data  = data;
    st = h + 1;
    while (in_s[st].cam) st++;
    if (op != 2'b11) begin
      ex[st].tag  = tag;
      ex[st].ubit = tag[0];
      ex[st].psz  = tag[3:1];
      ex[st].data = data;
    end
    err = 1'b0;
    case (op)
      2'b00: begin
        ex[st].wr   = 1'b1;
        ex[st].idxv = 1'b1;
        ex[st].idx  = ivld ? idx : m_repl;
        if (!ivld) begin
          m_repl = m_repl + 7'd1;
          fill_repl(st + 1, m_repl);
        end
        rc = st + 1;
      end
      2'b01: begin
        ex[st].rd   = 1'b1;
        ex[st].idxv = 1'b1;
        ex[st].idx  = idx;
        in_s[st + RD_LAT].ttag  = ~tag;
        in_s[st + RD_LAT].tdata = rdd;
        in_s[st + RD_LAT].tu    = ~tag[0];
        in_s[st + RD_LAT].par   = par;
        m_rtag  = ~tag;
        m_rdata = rdd;
        m_rubit = ~tag[0];
        err = ((^rdd) != par);
        rc = st + 1 + RD_LAT;
      end
      2'b10: begin
        ex[st].dm    = 1'b1;
        ex[st].idx   = idx;
        ex[st].dctx  = dq[2];
        ex[st].dall  = dq[1];
        ex[st].dreal = dq[0];
        if (dq[1]) begin
          m_repl = 7'd0;
          fill_repl(st + 1, m_repl);
        end
        rc = st + 1 + DMAP_GAP;
      end
      default: begin
        err = 1'b1;
        rc = st + 1;
      end
    endcase
    ex[rc].rvld  = 1'b1;
    ex[rc].rerr  = err;
    ex[rc].rtag  = m_rtag;
    ex[rc].rdata = m_rdata;
    ex[rc].rubit = m_rubit;
    for (int c = h + 1; c <= rc; c++) ex[c].rdy = 1'b0;
    so = st;
    ro = rc;
  endtask

  always @(negedge l2clk) begin
    if (built && cyc >= 1 && cyc < NCYC) begin
      chk("req_rdy", req_rdy, ex[cyc].rdy);
      chk("tlb_cam_vld", tlb_cam_vld, in_s[cyc].cam);
      chk("tlb_wr_vld", tlb_wr_vld, ex[cyc].wr);
      chk("tlb_rd_vld", tlb_rd_vld, ex[cyc].rd);
      chk("tlb_demap", tlb_demap, ex[cyc].dm);
      chk("tlb_demap_context", tlb_demap_context, ex[cyc].dctx);
      chk("tlb_demap_all", tlb_demap_all, ex[cyc].dall);
      chk("tlb_demap_real", tlb_demap_real, ex[cyc].dreal);
      chk("tlb_rw_index", tlb_rw_index, ex[cyc].idx);
      chk("tlb_rw_index_vld", tlb_rw_index_vld, ex[cyc].idxv);
      chk("tte_tag", tte_tag, ex[cyc].tag);
      chk("tte_ubit", tte_ubit, ex[cyc].ubit);
      chk("tte_page_size_mask", tte_page_size_mask, ex[cyc].psz);
      chk("tte_data", tte_data, ex[cyc].data);
      chk("rsp_vld", rsp_vld, ex[cyc].rvld);
      chk("repl_ptr", repl_ptr, ex[cyc].repl);
      if (ex[cyc].rvld) begin
        chk("rsp_err", rsp_err, ex[cyc].rerr);
        chk("rsp_tag", rsp_tag, ex[cyc].rtag);
        chk("rsp_data", rsp_data, ex[cyc].rdata);
        chk("rsp_ubit", rsp_ubit, ex[cyc].rubit);
      end
    end
  end

  task automatic at_cycle(input int c);
    do @(negedge l2clk); while (cyc < c);
  endtask

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      in_s[c] = '0;
      in_s[c].ttag  = {34'h2_5A5A_0F0F, 32'(c * 13 + 1)};
      in_s[c].tdata = 38'(c * 37 + 11);
      in_s[c].tu    = c[1];
      in_s[c].par   = c[0];
      ex[c] = '0;
    end
    apply_reset(0, 3);
    nh = 4;

    // Fill: 127 un-indexed writes plus one explicit write, back to back.
    for (int i = 0; i < 128; i++) begin
      issue(nh, 2'b00, (i == 10) ? 7'd9 : 7'(i * 3), (i == 10), 3'b000,
            {2'b10, 32'(i * 97 + 5), 32'hDEAD_0000 | 32'(i)}, 38'(i * 1001 + 7),
            38'd0, 1'b0, s, r);
      nh = r + 1;
    end
    issue(nh, 2'b00, 7'd4, 1'b0, 3'b000, 66'h3_0000_1111_2222_3333, 38'h12_3456_789A,
          38'd0, 1'b0, s1, r1);
    nh = r1 + 1;
    issue(nh, 2'b01, 7'd5, 1'b1, 3'b000, 66'h1_ABCD_0000_FFFF_0001, 38'h0,
          38'h1, 1'b1, s, r2);
    in_s[s + 1].cam = 1'b1;
    in_s[r2].cam = 1'b1;
    nh = r2 + 1;
    issue(nh, 2'b01, 7'd5, 1'b1, 3'b000, 66'h2_0F0F_1234_5678_9ABC, 38'h0,
          38'h1, 1'b0, s, r3);
    nh = r3 + 1;
    h4 = nh;
    for (int c = h4 + 1; c <= h4 + 4; c++) in_s[c].cam = 1'b1;
    issue(h4, 2'b00, 7'd33, 1'b1, 3'b000, 66'h0_1357_9BDF_2468_ACE0, 38'h3F_FFFF_FFFF,
          38'd0, 1'b0, s, r);
    nh = r + 1;
    issue(nh, 2'b00, 7'd0, 1'b0, 3'b000, 66'h1_1111_2222_3333_4444, 38'h05_0505_0505,
          38'd0, 1'b0, s, r);
    nh = r + 1;
    issue(nh, 2'b10, 7'd17, 1'b0, 3'b111, 66'h2_FEED_FACE_CAFE_BEEF, 38'h0,
          38'd0, 1'b0, s5, r5);
    nh = r5 + 1;
    issue(nh, 2'b00, 7'd0, 1'b0, 3'b000, 66'h0_0000_0000_0000_00FF, 38'h00_0000_00AA,
          38'd0, 1'b0, s, r);
    nh = r + 1;
    issue(nh, 2'b10, 7'd64, 1'b1, 3'b100, 66'h3_8000_0000_0000_0001, 38'h0,
          38'd0, 1'b0, s, r);
    in_s[s + 1].cam = 1'b1;
    nh = r + 1;
    issue(nh, 2'b11, 7'd1, 1'b1, 3'b000, 66'h0_DEAD_BEEF_0000_0000, 38'h1,
          38'd0, 1'b0, s, r6);
    nh = r6 + 1;
    issue(nh, 2'b00, 7'd0, 1'b0, 3'b000, 66'h1_0000_0000_0000_0010, 38'h2A_AAAA_AAAA,
          38'd0, 1'b0, s, r);
    nh = r + 1;
    h7 = nh;
    issue(h7, 2'b01, 7'd99, 1'b1, 3'b000, 66'h2_2222_3333_4444_5555, 38'h0,
          38'h15_5555_5555, 1'b0, s, r7);
    apply_reset(h7 + 2, h7 + 4);
    nh = h7 + 5;
    issue(nh, 2'b00, 7'd0, 1'b0, 3'b000, 66'h0_0000_0000_0000_0ABC, 38'h00_0000_0DEF,
          38'd0, 1'b0, s, r);
    nh = r + 1;
    issue(nh, 2'b01, 7'd77, 1'b1, 3'b000, 66'h1_0000_0000_0000_0002, 38'h0,
          38'h3, 1'b0, s, r);
    built = 1'b1;

    // Hand-computed expectations pinning the model.
    at_cycle(1);
    chk("lit_reset_rsp_vld", rsp_vld, 1'b0);
    chk("lit_reset_req_rdy", req_rdy, 1'b0);
    chk("lit_reset_repl", repl_ptr, 7'd0);
    at_cycle(3);
    chk("lit_postreset_rdy_low", req_rdy, 1'b0);
    at_cycle(4);
    chk("lit_postreset_rdy_high", req_rdy, 1'b1);
    at_cycle(s1);
    chk("lit_wrap_wr_vld", tlb_wr_vld, 1'b1);
    chk("lit_wrap_index", tlb_rw_index, 7'd127);
    at_cycle(r1);
    chk("lit_wrap_rsp_vld", rsp_vld, 1'b1);
    chk("lit_wrap_rsp_err", rsp_err, 1'b0);
    chk("lit_wrap_repl", repl_ptr, 7'd0);
    at_cycle(r2);
    chk("lit_rd_good_vld", rsp_vld, 1'b1);
    chk("lit_rd_good_data", rsp_data, 38'h1);
    chk("lit_rd_good_err", rsp_err, 1'b0);
    at_cycle(r3);
    chk("lit_rd_bad_err", rsp_err, 1'b1);
    at_cycle(h4 + 4);
    chk("lit_cam_block_wr", tlb_wr_vld, 1'b0);
    chk("lit_cam_block_cam", tlb_cam_vld, 1'b1);
    at_cycle(h4 + 5);
    chk("lit_cam_release_wr", tlb_wr_vld, 1'b1);
    chk("lit_cam_release_cam", tlb_cam_vld, 1'b0);
    at_cycle(s5);
    chk("lit_dmap_strobe", tlb_demap, 1'b1);
    chk("lit_dmap_all", tlb_demap_all, 1'b1);
    at_cycle(s5 + 1);
    chk("lit_dmap_gap1_rdy", req_rdy, 1'b0);
    at_cycle(s5 + 2);
    chk("lit_dmap_gap2_rdy", req_rdy, 1'b0);
    at_cycle(r5);
    chk("lit_dmap_rsp_vld", rsp_vld, 1'b1);
    chk("lit_dmap_repl", repl_ptr, 7'd0);
    at_cycle(r6);
    chk("lit_rsv_rsp_vld", rsp_vld, 1'b1);
    chk("lit_rsv_rsp_err", rsp_err, 1'b1);
    at_cycle(h7 + 2);
    chk("lit_midrst_rsp_vld", rsp_vld, 1'b0);
    chk("lit_midrst_rdy", req_rdy, 1'b0);
    chk("lit_midrst_repl", repl_ptr, 7'd0);
    at_cycle(r7);
    chk("lit_midrst_no_rsp", rsp_vld, 1'b0);
    at_cycle(h7 + 5);
    chk("lit_midrst_rdy_back", req_rdy, 1'b1);

    at_cycle(NCYC + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
